uart_tx: RTL and testbench
==========================

# uart_tx

Serial 8N1 transmitter that turns the debug unit's byte-wide transmit requests into the host-facing `tx` line. Sits directly downstream of the debug unit's response path: it consumes `tx_write`/`tx_data` and returns a one-cycle `tx_finished` per completed frame, which the debug unit uses to issue the next byte. It has a one-byte holding register, so a second byte written during a frame goes out back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per serial bit; must be >= 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `tx_write`  in  1  write strobe; each high cycle is one write of `tx_data`.
- `tx_data`  in  8  byte to send, sampled on the edge where `tx_write` is high.
- `tx`  out  1  serial line, registered, idle high.
- `tx_finished`  out  1  one-cycle pulse at the end of each frame's stop bit.
- `busy`  out  1  high while a frame is in progress or the holding register is full.
- `tx_overrun`  out  1  sticky; set when a write is dropped. Cleared only by reset.

## Operation
- Frame format: start bit (0), data bits 0–7 LSB first, stop bit (1). Each bit is exactly `CLKS_PER_BIT` cycles. A frame is `10*CLKS_PER_BIT` cycles.
- FSM states:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = shift register bit 0; 3-bit bit counter 0..7.
  - STOP: `tx`=1.
- Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1, and the state or bit advances when it wraps.
- IDLE with `tx_write`=1: load the shift register from `tx_data`, reset the baud counter, and go to START.
- After DATA bit 7, go to STOP. At the last cycle of STOP:
  - Pulse `tx_finished` for one cycle.
  - If the hold register is valid: load the shift register from hold, clear hold, and go to START. The start bit follows the stop bit directly.
  - Otherwise, if `tx_write`=1 on that same edge: load from `tx_data` and go to START.
  - Otherwise: go to IDLE.
- Write arriving while not in IDLE:
  - Hold empty: latch the byte into hold.
  - Hold full: drop the byte and set `tx_overrun`. The frame in progress and the hold contents are unaffected.
- `busy` = (state != IDLE) | hold_valid, registered.

## Timing
- Reset values, all asserted asynchronously while `n_reset`=0:
  - `tx`=1, `tx_finished`=0, `busy`=0, `tx_overrun`=0.
  - State IDLE, hold empty, counters 0.
- Reset mid-frame: `tx` returns high immediately, the frame is abandoned, the hold byte is discarded, and no `tx_finished` is generated.
- Latency: with `tx_write` sampled at edge N in IDLE, `tx`=0 is visible after edge N. The start bit covers edges N..N+CLKS_PER_BIT-1.
- `tx_finished` is high for the single cycle that follows the final STOP edge, i.e. edge N+10*CLKS_PER_BIT.
- `busy` rises after edge N. In the no-hold case it falls on the same edge that raises `tx_finished`.
- Back-to-back frames sent via the hold register, or via a write coincident with the final STOP edge, have zero idle cycles between the stop bit and the next start bit.
- `tx_data` only needs to be valid on the cycle `tx_write` is high.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
1. Reset: assert `n_reset`=0 mid-simulation -> `tx`=1, `busy`=0, `tx_finished`=0, `tx_overrun`=0 with no clock edge needed.
2. Single byte: pulse `tx_write` with 0xA5 at edge 0 -> `tx` runs 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `tx_finished` is high for exactly 1 cycle after edge 40. `busy` drops with it.
3. Hold: write 0x55 at edge 0 and 0x0F at edge 5 -> two contiguous frames, 80 cycles of `tx` with no idle, two `tx_finished` pulses (after edges 40 and 80), `tx_overrun`=0.
4. Overrun: write 0x11, 0x22, 0x33 at edges 0, 2, 4 -> 0x11 and 0x22 transmitted, 0x33 dropped. `tx_overrun`=1 from edge 4 and stays set.
5. Debug-unit handshake: write 0x3C; drive `tx_write` with 0xC3 on the cycle `tx_finished` is high -> 0xC3's start bit begins on the next bit slot. Exactly 2 `tx_finished` pulses total.
6. Reset mid-frame: write 0xFF, then assert `n_reset` at edge 17 -> `tx`=1 immediately. No `tx_finished` pulse. After release, a new write of 0x00 produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if
//   Byte-write handshake between the debug unit (master) and the serial
//   transmitter (slave).
//   tx_write    : write strobe, one byte per high cycle
//   tx_data     : byte to send, valid only while tx_write is high
//   tx_finished : one-cycle pulse when a frame's stop bit completes
//   busy        : frame in progress or holding register occupied
//   tx_overrun  : sticky flag, a write was dropped
interface uart_tx_if;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       tx_finished;
  logic       busy;
  logic       tx_overrun;

  modport master (
    output tx_write,
    output tx_data,
    input  tx_finished,
    input  busy,
    input  tx_overrun
  );

  modport slave (
    input  tx_write,
    input  tx_data,
    output tx_finished,
    output busy,
    output tx_overrun
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx
//   8N1 serial transmitter with a one-byte holding register, so a byte
//   written during a frame follows the current stop bit with no idle gap.
//   Ports:
//     clk     : system clock, rising-edge
//     n_reset : asynchronous active-low reset
//     bus     : byte-write handshake (uart_tx_if.slave)
//     tx      : registered serial line, idle high
//   CLKS_PER_BIT (>= 2) sets the bit period in clk cycles.
//
//   state | meaning
//   ------+--------------------------------------------
//   IDLE  | line high, waiting for a write
//   START | start bit (0) on the line
//   DATA  | data bits, LSB first, from shift_q[0]
//   STOP  | stop bit (1); last cycle may chain the next frame
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic     clk,
  input  logic     n_reset,
  uart_tx_if.slave bus,
  output logic     tx
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] baud_q, baud_nxt;
  logic [2:0]    bit_q, bit_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic [7:0]    hold_q, hold_nxt;
  logic          hold_v_q, hold_v_nxt;
  logic          ovr_q, ovr_nxt;
  logic          fin_q, fin_nxt;
  logic          busy_q, busy_nxt;
  logic          tx_q, tx_nxt;
  logic          baud_wrap;
  logic          write_to_shift;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      ovr_q    <= 1'b0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_nxt;
      baud_q   <= baud_nxt;
      bit_q    <= bit_nxt;
      shift_q  <= shift_nxt;
      hold_q   <= hold_nxt;
      hold_v_q <= hold_v_nxt;
      ovr_q    <= ovr_nxt;
      fin_q    <= fin_nxt;
      busy_q   <= busy_nxt;
      tx_q     <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    baud_nxt       = baud_q;
    bit_nxt        = bit_q;
    shift_nxt      = shift_q;
    hold_nxt       = hold_q;
    hold_v_nxt     = hold_v_q;
    ovr_nxt        = ovr_q;
    fin_nxt        = 1'b0;
    baud_wrap      = (baud_q == BAUD_LAST);
    write_to_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tx_write) begin
          shift_nxt      = bus.tx_data;
          baud_nxt       = '0;
          state_nxt      = START;
          write_to_shift = 1'b1;
        end
      end

      START: begin
        if (baud_wrap) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_q + CW'(1);
        end
      end

      DATA: begin
        if (baud_wrap) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_q + 3'd1;
          end
        end else begin
          baud_nxt = baud_q + CW'(1);
        end
      end

      STOP: begin
        if (baud_wrap) begin
          fin_nxt  = 1'b1;
          baud_nxt = '0;
          if (hold_v_q) begin
            shift_nxt  = hold_q;
            hold_v_nxt = 1'b0;
            state_nxt  = START;
          end else if (bus.tx_write) begin
            shift_nxt      = bus.tx_data;
            state_nxt      = START;
            write_to_shift = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_q + CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A write that did not go straight into the shift register targets the
    // holding register. Occupancy is judged on the pre-edge hold_v_q, so a
    // write on the final stop edge while the hold byte is being launched
    // still counts as an overrun.
    if (bus.tx_write && !write_to_shift) begin
      if (hold_v_q) begin
        ovr_nxt = 1'b1;
      end else begin
        hold_nxt   = bus.tx_data;
        hold_v_nxt = 1'b1;
      end
    end

    // Line level is registered from the next state so the start bit is
    // visible right after the accepting edge.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt != IDLE) | hold_v_nxt;
  end

  assign tx              = tx_q;
  assign bus.tx_finished = fin_q;
  assign bus.busy        = busy_q;
  assign bus.tx_overrun  = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
  localparam int C = 4;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic tx;

  uart_tx_if bus();

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: frame-level schedule of the transmitter.
  bit         m_active = 0;
  bit         m_hold_v = 0;
  logic [7:0] m_hold_b = '0;
  int         m_end    = 0;
  bit         exp_busy = 0;
  bit         exp_ovr  = 0;
  logic [7:0] q_byte[$];
  int         q_start[$];
  int         q_fin[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic start_frame(logic [7:0] b);
    m_active = 1;
    m_end    = cyc + 10 * C;
    q_byte.push_back(b);
    q_start.push_back(cyc);
  endtask

  task automatic model_edge(bit w, logic [7:0] d);
    if (m_active && cyc == m_end) begin
      q_fin.push_back(cyc);
      if (m_hold_v) begin
        if (w) exp_ovr = 1;
        m_hold_v = 0;
        start_frame(m_hold_b);
      end else if (w) begin
        start_frame(d);
      end else begin
        m_active = 0;
      end
    end else if (m_active) begin
      if (w) begin
        if (m_hold_v) exp_ovr = 1;
        else begin
          m_hold_v = 1;
          m_hold_b = d;
        end
      end
    end else if (w) begin
      start_frame(d);
    end
    exp_busy = m_active || m_hold_v;
  endtask

  task automatic step(bit w, logic [7:0] d);
    @(negedge clk);
    bus.tx_write = w;
    bus.tx_data  = w ? d : 8'($urandom);
    @(posedge clk);
    cyc++;
    if (n_reset) model_edge(w, d);
  endtask

  task automatic release_reset();
    @(negedge clk);
    n_reset      = 1'b1;
    bus.tx_write = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  task automatic reset_check(string tag);
    @(negedge clk);
    #1 n_reset = 1'b0;
    #1;
    check({tag, "_tx"},       tx,              32'd1);
    check({tag, "_busy"},     bus.busy,        32'd0);
    check({tag, "_finished"}, bus.tx_finished, 32'd0);
    check({tag, "_overrun"},  bus.tx_overrun,  32'd0);
    m_active = 0;
    m_hold_v = 0;
    exp_busy = 0;
    exp_ovr  = 0;
    q_byte.delete();
    q_start.delete();
    q_fin.delete();
    step(0, 8'h00);
    step(0, 8'h00);
    release_reset();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (m_active || m_hold_v); i++) step(0, 8'h00);
    repeat (3) step(0, 8'h00);
  endtask

  // Monitor: decodes the serial line and the finished pulses, pops the
  // scoreboard and compares; also tracks busy/overrun every cycle.
  bit         dec   = 0;
  int         dstart = 0;
  logic [9:0] dbits = '0;

  always @(negedge clk) begin : mon
    int rel;
    if (!n_reset) begin
      dec = 0;
    end else begin
      check("busy", bus.busy, exp_busy);
      check("overrun", bus.tx_overrun, exp_ovr);
      if (bus.tx_finished) begin
        if (q_fin.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL finished_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          check("finished_edge", cyc, q_fin.pop_front());
        end
      end
      if (!dec && tx == 1'b0) begin
        dec    = 1;
        dstart = cyc;
      end
      if (dec) begin
        rel = cyc - dstart;
        if (rel % C == C / 2) begin
          dbits[rel / C] = tx;
          if (rel / C == 9) begin
            dec = 0;
            if (q_byte.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL frame_unexpected: got byte %0h at cycle %0d, expected none", dbits[8:1], dstart);
            end else begin
              check("frame_data",  dbits[8:1], q_byte.pop_front());
              check("frame_start", dstart,     q_start.pop_front());
              check("start_bit",   dbits[0],   32'd0);
              check("stop_bit",    dbits[9],   32'd1);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    bus.tx_write = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) step(0, 8'h00);
    release_reset();
    step(0, 8'h00);

    // reset while idle
    reset_check("rst_idle");

    // single byte
    step(1, 8'hA5);
    drain();

    // hold register: two contiguous frames
    step(1, 8'h55);
    repeat (4) step(0, 8'h00);
    step(1, 8'h0F);
    drain();

    // handshake: write on the cycle tx_finished is high
    step(1, 8'h3C);
    e = m_end;
    while (cyc < e) step(0, 8'h00);
    step(1, 8'hC3);
    drain();

    // write coincident with the final stop edge
    step(1, 8'h81);
    e = m_end;
    while (cyc < e - 1) step(0, 8'h00);
    step(1, 8'h7E);
    drain();

    // overrun: third write dropped
    step(1, 8'h11);
    step(0, 8'h00);
    step(1, 8'h22);
    step(0, 8'h00);
    step(1, 8'h33);
    drain();

    // write on final stop edge while hold is full
    step(1, 8'h12);
    step(0, 8'h00);
    step(1, 8'h34);
    e = m_end;
    while (cyc < e - 1) step(0, 8'h00);
    step(1, 8'h56);
    drain();

    // reset mid-frame, then a clean frame
    step(1, 8'hFF);
    repeat (17) step(0, 8'h00);
    reset_check("rst_mid");
    step(1, 8'h00);
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) reset_check("rst_rand");
      step($urandom_range(0, 24) == 0, 8'($urandom));
    end
    drain();
    repeat (5) step(0, 8'h00);

    check("frames_left",   q_byte.size(), 32'd0);
    check("finished_left", q_fin.size(),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
